// File: rtl/instr_decode_pkg.sv
// Shared definitions for the instruction decoder: opcodes, decode states,
// special instruction encodings and the branch offset table.
package instr_decode_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_LOAD  = 3'b010,
    OP_STORE = 3'b011,
    OP_MOV   = 3'b100,
    OP_BLT   = 3'b101,
    OP_BNE   = 3'b110,
    OP_SYS   = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [8:0] NOP_INSTR   = 9'h1C0;
  localparam logic [8:0] HALT_INSTR  = 9'h1FF;
  localparam logic [5:0] SYS_HALT    = 6'h3F;
  localparam int         BR_LUT_DEPTH = 32;

  // Offsets are relative to the already-advanced PC and wrap modulo 256.
  localparam logic [7:0] BR_LUT [BR_LUT_DEPTH] = '{
    8'h02, 8'h04, 8'h08, 8'hFC,
    8'hF8, 8'h10, 8'hF0, 8'h20,
    8'hE0, 8'h03, 8'hFD, 8'h05,
    8'hFB, 8'h07, 8'hF9, 8'h0C,
    8'hF4, 8'h18, 8'hE8, 8'h30,
    8'hD0, 8'h01, 8'hFF, 8'h06,
    8'hFA, 8'h0A, 8'hF6, 8'h14,
    8'hEC, 8'h40, 8'hC0, 8'h7F
  };

  // SYS with any operand other than HALT behaves as a NOP.
  function automatic logic is_nop(input logic [8:0] ir);
    return (ir[8:6] == OP_SYS) && (ir[5:0] != SYS_HALT);
  endfunction

endpackage

// File: rtl/instr_decode_br_lut.sv
// Combinational branch offset lookup: 5-bit index into the shared 32x8 table.
module br_lut
  import instr_decode_pkg::*;
(
  input  logic [4:0] idx,
  output logic [7:0] offset
);

  logic [7:0] masked [BR_LUT_DEPTH];

  // One-hot select per entry, then OR-reduce; only the matching entry is non-zero.
  for (genvar gi = 0; gi < BR_LUT_DEPTH; gi++) begin : g_entry
    assign masked[gi] = (idx == 5'(gi)) ? BR_LUT[gi] : 8'h00;
  end

  always_comb begin
    offset = 8'h00;
    for (int i = 0; i < BR_LUT_DEPTH; i++) begin
      offset = offset | masked[i];
    end
  end

endmodule

// File: rtl/instr_decode.sv
// Instruction register, IDLE/RUN/HALTED sequencing and combinational decode
// of the held instruction, plus a saturating count of executed instructions.
module instr_decode
  import instr_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  instr,
  input  logic        flush,
  output logic        halt,
  output logic        branchsig,
  output logic        branchtype,
  output logic [7:0]  branch_offset,
  output logic [2:0]  alu_op,
  output logic [5:0]  operand,
  output logic        reg_we,
  output logic        mem_we,
  output logic        mem_re,
  output logic [15:0] instr_count
);

  state_e      state_reg;
  logic [8:0]  ir_reg;
  logic [15:0] count_reg;
  logic [7:0]  lut_offset;
  opcode_e     op;
  logic        is_run;

  assign op     = opcode_e'(ir_reg[8:6]);
  assign is_run = (state_reg == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ir_reg    <= NOP_INSTR;
      count_reg <= 16'h0000;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ir_reg <= NOP_INSTR;
          if (start) begin
            state_reg <= ST_RUN;
            ir_reg    <= instr;
          end
        end
        ST_RUN: begin
          if (!is_nop(ir_reg) && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
          end
          // HALT wins over a simultaneous flush and stays in IR.
          if (ir_reg == HALT_INSTR) begin
            state_reg <= ST_HALTED;
          end else if (flush) begin
            ir_reg <= NOP_INSTR;
          end else begin
            ir_reg <= instr;
          end
        end
        ST_HALTED: begin
          state_reg <= ST_HALTED;
        end
        default: begin
          state_reg <= ST_IDLE;
          ir_reg    <= NOP_INSTR;
        end
      endcase
    end
  end

  br_lut u_br_lut (
    .idx    (ir_reg[4:0]),
    .offset (lut_offset)
  );

  always_comb begin
    halt          = !is_run || (ir_reg == HALT_INSTR);
    branchsig     = 1'b0;
    branchtype    = 1'b0;
    branch_offset = 8'h00;
    alu_op        = 3'b000;
    operand       = 6'h00;
    reg_we        = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    if (is_run) begin
      alu_op  = ir_reg[8:6];
      operand = ir_reg[5:0];
      case (op)
        OP_ADD, OP_SUB, OP_MOV: reg_we = 1'b1;
        OP_LOAD: begin
          reg_we = 1'b1;
          mem_re = 1'b1;
        end
        OP_STORE: mem_we = 1'b1;
        OP_BLT, OP_BNE: begin
          branchsig     = 1'b1;
          branchtype    = (op == OP_BNE);
          branch_offset = lut_offset;
        end
        default: ;
      endcase
    end
  end

  assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed vector table, saturation and
// reset sequence, then randomized traffic against a behavioural model.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [8:0]  instr;
  logic        halt, branchsig, branchtype, reg_we, mem_we, mem_re;
  logic [7:0]  branch_offset;
  logic [2:0]  alu_op;
  logic [5:0]  operand;
  logic [15:0] instr_count;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [8:0] NOP  = 9'h1C0;
  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [7:0] REF_LUT [32] = '{
    8'h02, 8'h04, 8'h08, 8'hFC, 8'hF8, 8'h10, 8'hF0, 8'h20,
    8'hE0, 8'h03, 8'hFD, 8'h05, 8'hFB, 8'h07, 8'hF9, 8'h0C,
    8'hF4, 8'h18, 8'hE8, 8'h30, 8'hD0, 8'h01, 8'hFF, 8'h06,
    8'hFA, 8'h0A, 8'hF6, 8'h14, 8'hEC, 8'h40, 8'hC0, 8'h7F
  };

  always #5 clk = ~clk;

  instr_decode dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .flush(flush),
    .halt(halt), .branchsig(branchsig), .branchtype(branchtype),
    .branch_offset(branch_offset), .alu_op(alu_op), .operand(operand),
    .reg_we(reg_we), .mem_we(mem_we), .mem_re(mem_re), .instr_count(instr_count)
  );

  wire [38:0] dut_bus = {halt, branchsig, branchtype, branch_offset, alu_op,
                         operand, reg_we, mem_we, mem_re, instr_count};

  // Behavioural model: running/halted flags, held word, executed count.
  bit         m_run, m_halted;
  logic [8:0] m_ir;
  int         m_count;

  function automatic bit ref_is_nop(input logic [8:0] w);
    return (w / 64 == 7) && (w % 64 != 63);
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit f, input logic [8:0] i);
    if (r) begin
      m_run = 0; m_halted = 0; m_ir = NOP; m_count = 0;
    end else if (m_halted) begin
    end else if (!m_run) begin
      if (s) begin m_run = 1; m_ir = i; end
    end else begin
      if (!ref_is_nop(m_ir)) m_count = (m_count >= 65535) ? 65535 : m_count + 1;
      if (m_ir == HALT) begin m_run = 0; m_halted = 1; end
      else m_ir = f ? NOP : i;
    end
  endtask

  function automatic logic [38:0] model_bus();
    int op, opnd;
    logic h, br, bt, rw, mw, mr;
    logic [7:0] off;
    logic [2:0] a;
    logic [5:0] o;
    op = int'(m_ir) / 64;
    opnd = int'(m_ir) % 64;
    h = !m_run || (m_ir == HALT);
    br = 0; bt = 0; rw = 0; mw = 0; mr = 0; off = 0; a = 0; o = 0;
    if (m_run) begin
      a  = 3'(op);
      o  = 6'(opnd);
      rw = (op == 0 || op == 1 || op == 2 || op == 4);
      mr = (op == 2);
      mw = (op == 3);
      br = (op == 5 || op == 6);
      bt = (op == 6);
      off = br ? REF_LUT[opnd % 32] : 8'h00;
    end
    return {h, br, bt, off, a, o, rw, mw, mr, 16'(m_count)};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, sample #1 later.
  task automatic cycle(input bit r, input bit s, input bit f, input logic [8:0] i);
    reset = r; start = s; flush = f; instr = i;
    @(posedge clk);
    model_edge(r, s, f, i);
    #1;
  endtask

  typedef struct {
    bit         r, s, f;
    logic [8:0] i;
    bit         e_halt, e_rw, e_mw, e_mr, e_br, e_bt;
    logic [7:0] e_off;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // r s f  instr   halt rw mw mr br bt off  count
    tbl[0]  = '{1,0,0,9'h000, 1,0,0,0,0,0,8'h00,16'd0};
    tbl[1]  = '{0,0,0,9'h000, 1,0,0,0,0,0,8'h00,16'd0};
    tbl[2]  = '{0,0,0,9'h000, 1,0,0,0,0,0,8'h00,16'd0};
    tbl[3]  = '{0,0,0,9'h000, 1,0,0,0,0,0,8'h00,16'd0};
    tbl[4]  = '{0,0,0,9'h000, 1,0,0,0,0,0,8'h00,16'd0};
    tbl[5]  = '{0,0,0,9'h000, 1,0,0,0,0,0,8'h00,16'd0};
    tbl[6]  = '{0,1,0,9'h005, 0,1,0,0,0,0,8'h00,16'd0};  // ADD
    tbl[7]  = '{0,0,0,9'h04A, 0,1,0,0,0,0,8'h00,16'd1};  // SUB
    tbl[8]  = '{0,0,0,9'h083, 0,1,0,1,0,0,8'h00,16'd2};  // LOAD
    tbl[9]  = '{0,0,0,9'h183, 0,0,0,0,1,1,8'hFC,16'd3};  // BNE idx 3
    tbl[10] = '{0,0,1,9'h0C1, 0,0,0,0,0,0,8'h00,16'd4};  // flushed STORE
    tbl[11] = '{0,0,0,9'h10F, 0,1,0,0,0,0,8'h00,16'd4};  // MOV
    tbl[12] = '{0,0,0,9'h1FF, 1,0,0,0,0,0,8'h00,16'd5};  // HALT
    tbl[13] = '{0,0,1,9'h005, 1,0,0,0,0,0,8'h00,16'd6};
    tbl[14] = '{0,1,0,9'h005, 1,0,0,0,0,0,8'h00,16'd6};
    tbl[15] = '{0,0,0,9'h0C1, 1,0,0,0,0,0,8'h00,16'd6};
    tbl[16] = '{1,0,0,9'h0C1, 1,0,0,0,0,0,8'h00,16'd0};
    tbl[17] = '{0,1,0,9'h140, 0,0,0,0,1,0,8'h02,16'd0};  // BLT idx 0

    reset = 1; start = 0; flush = 0; instr = 9'h000;
    m_run = 0; m_halted = 0; m_ir = NOP; m_count = 0;

    for (int k = 0; k < 18; k++) begin
      cycle(tbl[k].r, tbl[k].s, tbl[k].f, tbl[k].i);
      check($sformatf("vec%0d.halt", k), 39'(halt), 39'(tbl[k].e_halt));
      check($sformatf("vec%0d.we_re", k), 39'({reg_we, mem_we, mem_re}),
            39'({tbl[k].e_rw, tbl[k].e_mw, tbl[k].e_mr}));
      check($sformatf("vec%0d.branch", k), 39'({branchsig, branchtype, branch_offset}),
            39'({tbl[k].e_br, tbl[k].e_bt, tbl[k].e_off}));
      check($sformatf("vec%0d.count", k), 39'(instr_count), 39'(tbl[k].e_cnt));
      $display("vec %0d instr=%h halt=%b count=%0d", k, tbl[k].i, halt, instr_count);
    end
    check("halt_alu_op_after_vecs", dut_bus, model_bus());

    // Saturation: stream non-NOPs until the count is one short of full.
    cycle(1, 0, 0, 9'h000);
    cycle(0, 1, 0, 9'h005);
    for (int k = 0; k < 70000 && m_count < 16'hFFFE; k++) cycle(0, 0, 0, 9'h005);
    check("sat.at_fffe", 39'(instr_count), 39'(16'hFFFE));
    cycle(0, 0, 0, 9'h04A);
    cycle(0, 0, 0, 9'h083);
    cycle(0, 0, 0, 9'h10F);
    check("sat.at_ffff", 39'(instr_count), 39'(16'hFFFF));
    check("sat.bus", dut_bus, model_bus());
    $display("saturation count=%h", instr_count);
    cycle(1, 0, 0, 9'h005);
    check("midrun_reset.count", 39'(instr_count), 39'd0);
    check("midrun_reset.halt", 39'({halt, reg_we, branchsig, alu_op}), 39'({1'b1, 1'b0, 1'b0, 3'b000}));
    $display("mid-run reset halt=%b count=%0d", halt, instr_count);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [8:0] w;
      int sel;
      sel = $urandom_range(0, 15);
      if (sel == 0) w = HALT;
      else if (sel == 1) w = NOP;
      else if (sel == 2) w = {3'b111, 6'($urandom_range(0, 63))};
      else w = 9'($urandom_range(0, 511));
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, w);
      check($sformatf("rand%0d", k), dut_bus, model_bus());
      $display("rand %0d r=%b s=%b f=%b instr=%h bus=%h", k, reset, start, flush, w, dut_bus);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
